// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the GPR file / write scoreboard slice.
package regfile_scoreboard_pkg;

    // Default geometry of the MIPS core register file
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NRD_DEF    = 2;
    localparam int unsigned CNT_W_DEF  = 2;

    // Hard-wired zero register index
    localparam int unsigned GPR_ZERO   = 0;

endpackage

// File: rtl/rf_pend_counter.sv
// Per-register count of in-flight writes.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : one issue targets this register this cycle
//   dec       : number of retirements (writeback + cancel) this cycle, 0..2
//   cnt       : current outstanding-write count
//   full      : count is at its maximum (no further issue allowed)
//   underflow : this cycle retires more writes than are outstanding
module rf_pend_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] PMAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_next;

    // Next count, floored at zero; overflow is prevented upstream by full
    always_comb begin
        w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(inc);
        underflow = w_sum < (CNT_W+1)'(dec);
        w_next    = underflow ? '0 : CNT_W'(w_sum - (CNT_W+1)'(dec));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign cnt  = r_cnt;
    assign full = (r_cnt == PMAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with NRD combinational read ports, write-through bypass and a
// per-register scoreboard of in-flight writes.
//   rd_addr/rd_data/rd_busy : read ports (packed, port i at slice i)
//   iss_valid/iss_addr      : issue marking a destination pending; iss_ready accepts it
//   wb_en/wb_addr/wb_data   : writeback, retires one pending write
//   cancel_en/cancel_addr   : flushed instruction abandons its pending write
//   pending_any             : some register still has outstanding writes
//   err                     : sticky protocol error (dropped issue or retire underflow)
//   debug_addr/debug_data   : raw array read
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NRD    = NRD_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_ready,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    cancel_en,
    input  logic [ADDR_W-1:0]       cancel_addr,
    output logic                    pending_any,
    output logic                    err,
    input  logic [ADDR_W-1:0]       debug_addr,
    output logic [DATA_W-1:0]       debug_data
);

    localparam int unsigned NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(GPR_ZERO);

    logic [DATA_W-1:0] r_gpr [NREG];
    logic              r_err;

    logic [CNT_W-1:0]  w_cnt [NREG];
    logic [1:0]        w_dec [NREG];
    logic [NREG-1:0]   w_inc;
    logic [NREG-1:0]   w_full;
    logic [NREG-1:0]   w_unf;
    logic [ADDR_W-1:0] w_rd_a [NRD];
    logic              w_iss_fire;
    logic              w_iss_drop;

    // Issue acceptance looks only at registered counts (no same-cycle retire credit)
    assign iss_ready  = !w_full[iss_addr] || (iss_addr == ZERO_A);
    assign w_iss_fire = iss_valid && iss_ready;
    assign w_iss_drop = iss_valid && !iss_ready;

    // Per-register inc/dec; r0 never sees traffic so its counter stays at zero
    always_comb begin
        w_inc = '0;
        for (int unsigned a = 0; a < NREG; a++) begin
            w_inc[a] = w_iss_fire && (iss_addr == ADDR_W'(a)) && (a != GPR_ZERO);
            w_dec[a] = 2'(wb_en && (wb_addr == ADDR_W'(a)) && (a != GPR_ZERO))
                     + 2'(cancel_en && (cancel_addr == ADDR_W'(a)) && (a != GPR_ZERO));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        rf_pend_counter #(
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (w_inc[g]),
            .dec       (w_dec[g]),
            .cnt       (w_cnt[g]),
            .full      (w_full[g]),
            .underflow (w_unf[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_rd_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Read muxes: bypass the in-flight writeback; a single retiring write clears busy
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (wb_en && (wb_addr == w_rd_a[i]) && (w_rd_a[i] != ZERO_A)) begin
                rd_data[i*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = r_gpr[w_rd_a[i]];
            end
            rd_busy[i] = (w_cnt[w_rd_a[i]] != '0)
                      && !(wb_en && (wb_addr == w_rd_a[i]) && (w_cnt[w_rd_a[i]] == CNT_W'(1)));
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int unsigned a = 0; a < NREG; a++) begin
            pending_any = pending_any | (w_cnt[a] != '0);
        end
    end

    // Register array; r0 is never written so it reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < NREG; a++) begin
                r_gpr[a] <= '0;
            end
        end else if (wb_en && (wb_addr != ZERO_A)) begin
            r_gpr[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_iss_drop | (|w_unf);
        end
    end

    assign err        = r_err;
    assign debug_data = r_gpr[debug_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;
    localparam int unsigned CW   = 2;
    localparam int unsigned NREG = 32;
    localparam int          PMAX = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_valid;
    logic [AW-1:0]         iss_addr;
    logic                  iss_ready;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [DW-1:0]         wb_data;
    logic                  cancel_en;
    logic [AW-1:0]         cancel_addr;
    logic                  pending_any;
    logic                  err;
    logic [AW-1:0]         debug_addr;
    logic [DW-1:0]         debug_data;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W (DW), .ADDR_W (AW), .NRD (NRD), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst (rst),
        .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
        .iss_valid (iss_valid), .iss_addr (iss_addr), .iss_ready (iss_ready),
        .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
        .cancel_en (cancel_en), .cancel_addr (cancel_addr),
        .pending_any (pending_any), .err (err),
        .debug_addr (debug_addr), .debug_data (debug_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference state: register contents, outstanding-write counts, error flag
    logic [DW-1:0] m_gpr [NREG];
    int            m_cnt [NREG];
    bit            m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge
    always @(posedge clk) begin
        bit ready;
        bit fire;
        int inc;
        int dec;
        int n;
        if (rst) begin
            for (int a = 0; a < NREG; a++) begin
                m_gpr[a] = '0;
                m_cnt[a] = 0;
            end
            m_err = 1'b0;
        end else begin
            ready = (iss_addr == 0) || (m_cnt[iss_addr] < PMAX);
            fire  = iss_valid && ready && (iss_addr != 0);
            if (iss_valid && !ready) m_err = 1'b1;
            for (int a = 1; a < NREG; a++) begin
                inc = (fire && iss_addr == AW'(a)) ? 1 : 0;
                dec = ((wb_en && wb_addr == AW'(a)) ? 1 : 0)
                    + ((cancel_en && cancel_addr == AW'(a)) ? 1 : 0);
                n = m_cnt[a] + inc - dec;
                if (n < 0) begin
                    n = 0;
                    m_err = 1'b1;
                end
                m_cnt[a] = n;
            end
            if (wb_en && wb_addr != 0) m_gpr[wb_addr] = wb_data;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        int            hit;
        bit            any;
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                a   = rd_addr[i*AW +: AW];
                hit = (wb_en && wb_addr == a) ? 1 : 0;
                if (a == 0)       exp_d = '0;
                else if (hit > 0) exp_d = wb_data;
                else              exp_d = m_gpr[a];
                chk($sformatf("model rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(exp_d));
                chk($sformatf("model rd_busy[%0d]", i), 64'(rd_busy[i]),
                    64'((m_cnt[a] - hit) > 0));
            end
            chk("model iss_ready", 64'(iss_ready),
                64'((iss_addr == 0) || (m_cnt[iss_addr] < PMAX)));
            any = 1'b0;
            for (int k = 0; k < NREG; k++) if (m_cnt[k] > 0) any = 1'b1;
            chk("model pending_any", 64'(pending_any), 64'(any));
            chk("model err", 64'(err), 64'(m_err));
            chk("model debug_data", 64'(debug_data), 64'(m_gpr[debug_addr]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        iss_valid = 1'b0; wb_en = 1'b0; cancel_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        cancel_en = 1'b0; cancel_addr = '0; debug_addr = '0;
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;

        // Reset state on both ports
        rd_addr = {5'd31, 5'd2};
        settle();
        chk("reset rd_data", 64'(rd_data), 64'h0);
        chk("reset rd_busy", 64'(rd_busy), 64'h0);
        chk("reset iss_ready", 64'(iss_ready), 64'h1);
        chk("reset pending_any", 64'(pending_any), 64'h0);
        chk("reset err", 64'(err), 64'h0);

        // Issue r5, then writeback with same-cycle bypass
        iss_valid = 1'b1; iss_addr = 5'd5;
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        settle();
        chk("r5 busy after issue", 64'(rd_busy[0]), 64'h1);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        settle();
        chk("r5 bypass data", 64'(rd_data[DW-1:0]), 64'h1234);
        chk("r5 busy cleared by wb", 64'(rd_busy[0]), 64'h0);
        tick();
        idle();
        debug_addr = 5'd5;
        settle();
        chk("r5 array value", 64'(debug_data), 64'h1234);
        chk("r5 pending cleared", 64'(pending_any), 64'h0);

        // Fill r7 to PMAX, then an extra issue is dropped
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick(); tick(); tick();
        settle();
        chk("r7 full iss_ready", 64'(iss_ready), 64'h0);
        chk("r7 full err still 0", 64'(err), 64'h0);
        tick();
        idle();
        settle();
        chk("r7 dropped issue err", 64'(err), 64'h1);
        rd_addr = {5'd7, 5'd0};
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        settle();
        chk("r7 busy at 3 with wb", 64'(rd_busy[1]), 64'h1);
        tick(); tick();
        settle();
        chk("r7 busy falls on 3rd wb", 64'(rd_busy[1]), 64'h0);
        tick();
        idle();
        settle();
        chk("r7 drained", 64'(pending_any), 64'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Issue r3 twice, then cancel and wb in one cycle
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick(); tick();
        idle();
        rd_addr = {5'd0, 5'd3};
        cancel_en = 1'b1; cancel_addr = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
        settle();
        chk("r3 bypass with cancel", 64'(rd_data[DW-1:0]), 64'hAA);
        tick();
        idle();
        settle();
        chk("r3 busy after cancel+wb", 64'(rd_busy[0]), 64'h0);
        chk("r3 err", 64'(err), 64'h0);
        chk("r3 pending", 64'(pending_any), 64'h0);
        chk("r3 array", 64'(rd_data[DW-1:0]), 64'hAA);

        // Writeback with nothing pending
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        tick();
        idle();
        debug_addr = 5'd9;
        settle();
        chk("r9 data written", 64'(debug_data), 64'h99);
        chk("r9 underflow err", 64'(err), 64'h1);
        chk("r9 no pending", 64'(pending_any), 64'h0);

        // r0 ignores issue and writeback
        iss_valid = 1'b1; iss_addr = 5'd0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        rd_addr = {5'd0, 5'd0};
        settle();
        chk("r0 bypass blocked", 64'(rd_data), 64'h0);
        chk("r0 never busy", 64'(rd_busy), 64'h0);
        chk("r0 iss_ready", 64'(iss_ready), 64'h1);
        tick();
        idle();
        settle();
        chk("r0 still zero", 64'(rd_data), 64'h0);
        chk("r0 no pending", 64'(pending_any), 64'h0);

        // Dual-port reads of two different registers with one bypassed
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_addr = 5'd13; wb_data = 32'hCAFE_0001;
        rd_addr = {5'd12, 5'd13};
        settle();
        chk("dual read", 64'(rd_data), 64'hDEAD_BEEF_CAFE_0001);
        tick();
        idle();

        // Reset in the middle of outstanding writes to r4
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        tick();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick(); tick();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
        tick();
        rst = 1'b0;
        idle();
        rd_addr = {5'd0, 5'd4};
        debug_addr = 5'd4;
        settle();
        chk("rst r4 busy", 64'(rd_busy[0]), 64'h0);
        chk("rst pending_any", 64'(pending_any), 64'h0);
        chk("rst r4 value", 64'(debug_data), 64'h0);
        chk("rst err", 64'(err), 64'h0);
        tick(); tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
